paddle_controller: RTL and testbench
====================================

# paddle_controller

Upstream stage of the enemy/collision logic. It turns the two raw player push-buttons into the paddle position `x_paddle1`/`y_paddle1`, which collision detection compares against the falling enemy. Buttons are synchronised and debounced, and the paddle moves on a fixed movement tick, accelerating while a button is held. The position is clamped so the 50-pixel paddle never leaves the 640-pixel screen.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a debounced button level changes
- `TICK_CYCLES`, 250000: clock cycles per movement tick
- `STEP_SLOW`, 1: pixels moved per tick before ramp
- `STEP_FAST`, 4: pixels moved per tick after ramp
- `RAMP_TICKS`, 8: number of slow ticks in one direction before switching to fast
- `X_RESET`, 295: paddle x after reset
- `clk`  in  1: system clock (pixel-domain clock, same as enemy logic)
- `rst`  in  1: reset, synchronous, active-high; one clock; reset is synchronous and active-high
- `btn_left`  in  1: raw asynchronous button, active-high
- `btn_right`  in  1: raw asynchronous button, active-high
- `enable`  in  1: game running; low freezes the paddle
- `x_paddle1`  out  16: paddle left edge, range [0, 590]
- `y_paddle1`  out  16: paddle top edge, constant 440
- `moving`  out  1: high while the FSM is in MOVE_L or MOVE_R

## Operation
- Each button passes through a 2-flop synchroniser, then a debouncer.
- Debouncer counter: reloads to 0 whenever the synced input differs from the debounced output. When it reaches DEBOUNCE_CYCLES-1 with the input still different, the output takes the input value and the counter clears.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. `tick` is high for exactly one cycle, on the wrap. It free-runs regardless of `enable` and FSM state.
- FSM states: IDLE, MOVE_L, MOVE_R. Next state is evaluated every cycle from the debounced levels L and R:
  - `enable`=0, or L=R: IDLE
  - L=1, R=0: MOVE_L
  - L=0, R=1: MOVE_R
- Hold counter (saturating at RAMP_TICKS):
  - Clears on any state change and in IDLE.
  - Increments on each tick taken in MOVE_L or MOVE_R.
- step = STEP_SLOW while hold < RAMP_TICKS, else STEP_FAST.
- On a cycle where `tick`=1, the registered state is MOVE_L and `enable`=1:
  - x <= (x < step) ? 0 : x - step
- On the same condition with state MOVE_R:
  - x <= (x + step > 590) ? 590 : x + step
- Clamp compares are done in 17 bits, so no wrap-around is possible.
- A state change and a tick in the same cycle: the move uses the old registered state, and the hold counter clears (state change wins).
- `y_paddle1` is a constant 440; it is not registered logic but still reads 440 in reset.

## Timing
- Reset values: x_paddle1=X_RESET, y_paddle1=440, moving=0, state IDLE; all counters, sync flops and debounced levels 0.
- `rst` asserted mid-move: at the next edge every register returns to its reset value. No move is applied on that edge, even if `tick`=1.
- Button-to-debounced latency:
  - 2 cycles (sync) + DEBOUNCE_CYCLES cycles of stable input.
  - Glitches shorter than that never propagate.
- Debounced change to state change: 1 cycle. `moving` follows state with no extra delay (decoded from the state register).
- Position update lands on the clock edge where `tick`=1, so x is visible the cycle after the tick.
- At most one step is taken per tick.

## Structure
- Shared package `game_pkg`:
  - Constants SCREEN_W=640, SCREEN_H=480, PADDLE_W=50, Y_PADDLE=440, X_MAX=SCREEN_W-PADDLE_W.
  - Typedef `coord_t` (16-bit logic).
  - Enum `paddle_state_t` {IDLE, MOVE_L, MOVE_R}.
- Sub-module `button_debounce` (synchroniser + debouncer, parameter DEBOUNCE_CYCLES), instantiated twice.
- The tick counter, FSM, hold counter and position register live in `paddle_controller`.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_CYCLES=10, RAMP_TICKS=3.
- **Reset:** assert `rst` 2 cycles -> x_paddle1=295, y_paddle1=440, moving=0.
- **Glitch reject:** 3-cycle `btn_left` pulse -> moving stays 0, x stays 295.
- **Hold right for 6 ticks:**
  - x goes 296, 297, 298, then 302, 306, 310 (ramp after 3 ticks).
  - moving=1 from 7 cycles after the press.
- **Clamp:** start near x=588 holding right -> x saturates at 590. Start near x=2 holding left in fast mode -> x saturates at 0, with no wrap to 65535.
- **Conflict:** both buttons held -> state IDLE, x frozen. Release right -> MOVE_L with the hold counter restarted at slow step.
- **Enable and reset mid-move:**
  - `enable`=0 during MOVE_R -> x frozen, moving=0.
  - `rst` pulse coincident with `tick` -> x=295, with no step applied.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and types for the paddle and enemy/collision logic.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PADDLE_W = 50;
  localparam int unsigned Y_PADDLE = 440;
  localparam int unsigned X_MAX    = SCREEN_W - PADDLE_W;

  typedef logic [15:0] coord_t;

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} paddle_state_t;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw push-button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    // The counter only runs while the synced input disagrees with the output.
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/paddle_controller.sv
// Turns two raw player buttons into a clamped, tick-paced, accelerating paddle position.
module paddle_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_CYCLES     = 250000,
  parameter int unsigned STEP_SLOW       = 1,
  parameter int unsigned STEP_FAST       = 4,
  parameter int unsigned RAMP_TICKS      = 8,
  parameter int unsigned X_RESET         = 295
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_left,
  input  logic   btn_right,
  input  logic   enable,
  output coord_t x_paddle1,
  output coord_t y_paddle1,
  output logic   moving
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned HoldW = $clog2(RAMP_TICKS + 1);

  logic             lvl_l, lvl_r;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  paddle_state_t    state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  coord_t           x_q, x_d;
  coord_t           step;
  logic [16:0]      sum_r;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_left),
    .level_o (lvl_l)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk_i   (clk),
    .rst_i   (rst),
    .btn_i   (btn_right),
    .level_o (lvl_r)
  );

  assign tick       = (tick_cnt_q == TickW'(TICK_CYCLES - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    state_d = IDLE;
    if (enable && (lvl_l != lvl_r)) begin
      state_d = lvl_l ? MOVE_L : MOVE_R;
    end
  end

  always_comb begin
    hold_d = hold_q;
    // A direction change wins over a coincident tick.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      hold_d = '0;
    end else if (tick && (hold_q < HoldW'(RAMP_TICKS))) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_comb begin
    step  = (hold_q < HoldW'(RAMP_TICKS)) ? coord_t'(STEP_SLOW) : coord_t'(STEP_FAST);
    sum_r = {1'b0, x_q} + {1'b0, step};
    x_d   = x_q;
    if (tick && enable) begin
      unique case (state_q)
        MOVE_L:  x_d = (x_q < step) ? '0 : x_q - step;
        MOVE_R:  x_d = (sum_r > 17'(X_MAX)) ? coord_t'(X_MAX) : sum_r[15:0];
        default: x_d = x_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      hold_q     <= '0;
      x_q        <= coord_t'(X_RESET);
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      x_q        <= x_d;
    end
  end

  assign x_paddle1 = x_q;
  assign y_paddle1 = coord_t'(Y_PADDLE);
  assign moving    = (state_q == MOVE_L) || (state_q == MOVE_R);

endmodule

// File: tb/tb_paddle_controller.sv
// Self-checking bench: directed vector table, corner sequences and random stimulus vs a model.
module tb_paddle_controller;

  localparam int DEB   = 4;
  localparam int TICK  = 10;
  localparam int RAMP  = 3;
  localparam int SLOW  = 1;
  localparam int FAST  = 4;
  localparam int XRST  = 295;
  localparam int XMAX  = 590;
  localparam int YPAD  = 440;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bl = 1'b0, br = 1'b0, en = 1'b1;
  logic [15:0] x_paddle1, y_paddle1;
  logic        moving;

  int errors = 0;
  int checks = 0;

  paddle_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .TICK_CYCLES     (TICK),
    .STEP_SLOW       (SLOW),
    .STEP_FAST       (FAST),
    .RAMP_TICKS      (RAMP),
    .X_RESET         (XRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (bl),
    .btn_right (br),
    .enable    (en),
    .x_paddle1 (x_paddle1),
    .y_paddle1 (y_paddle1),
    .moving    (moving)
  );

  always #5 clk = ~clk;

  // Reference model: position in plain integers, direction as -1/0/+1.
  int m_x, m_dir, m_hold, m_cyc;
  int m_run[2];
  bit m_s1[2], m_s2[2], m_lvl[2];

  task automatic model_reset();
    m_x = XRST; m_dir = 0; m_hold = 0; m_cyc = 0;
    for (int b = 0; b < 2; b++) begin
      m_run[b] = 0; m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0;
    end
  endtask

  task automatic model_edge();
    bit raw[2];
    bit nlvl[2];
    bit tk;
    int ndir, step;
    raw[0] = bl; raw[1] = br;
    tk = (m_cyc == TICK - 1);
    if (!en || m_lvl[0] == m_lvl[1]) ndir = 0;
    else ndir = m_lvl[0] ? -1 : 1;
    for (int b = 0; b < 2; b++) begin
      nlvl[b] = m_lvl[b];
      if (m_s2[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          nlvl[b] = m_s2[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    if (tk && en && m_dir != 0) begin
      step = (m_hold < RAMP) ? SLOW : FAST;
      m_x = m_x + m_dir * step;
      if (m_x < 0) m_x = 0;
      if (m_x > XMAX) m_x = XMAX;
    end
    if (ndir != m_dir || m_dir == 0) m_hold = 0;
    else if (tk && m_hold < RAMP) m_hold++;
    m_dir = ndir;
    for (int b = 0; b < 2; b++) begin
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
      m_lvl[b] = nlvl[b];
    end
    m_cyc = (m_cyc + 1) % TICK;
    if (rst) model_reset();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  bit model_ok = 0;

  task automatic clk_cycle();
    @(posedge clk);
    model_edge();
    if (rst) model_ok = 1;
    #1;
    if (model_ok) begin
      check("model_x", 32'(x_paddle1), 32'(m_x));
      check("model_moving", 32'(moving), 32'(m_dir != 0));
      check("y_paddle1", 32'(y_paddle1), YPAD);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk_cycle();
  endtask

  typedef struct {
    int rst;
    int left;
    int right;
    int en;
    int cycles;
    int exp_x;
    int exp_mov;
  } vec_t;

  vec_t vecs[$];
  int   xr;
  bit   found;

  initial begin
    model_reset();
    // Reset, glitch rejection, then hold right for 6 ticks from a fresh reset.
    vecs.push_back('{1, 0, 0, 1, 2, 295, 0});
    vecs.push_back('{0, 1, 0, 1, 3, 295, 0});
    vecs.push_back('{0, 0, 0, 1, 8, 295, 0});
    vecs.push_back('{1, 0, 0, 1, 2, 295, 0});
    vecs.push_back('{0, 0, 1, 1, 6, 295, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 295, 1});
    vecs.push_back('{0, 0, 1, 1, 3, 296, 1});
    vecs.push_back('{0, 0, 1, 1, 10, 297, 1});
    vecs.push_back('{0, 0, 1, 1, 10, 298, 1});
    vecs.push_back('{0, 0, 1, 1, 10, 302, 1});
    vecs.push_back('{0, 0, 1, 1, 10, 306, 1});
    vecs.push_back('{0, 0, 1, 1, 10, 310, 1});
    vecs.push_back('{0, 0, 0, 1, 7, 310, 0});

    for (int v = 0; v < vecs.size(); v++) begin
      rst = vecs[v].rst[0]; bl = vecs[v].left[0]; br = vecs[v].right[0]; en = vecs[v].en[0];
      run(vecs[v].cycles);
      check($sformatf("vec%0d_x", v), 32'(x_paddle1), vecs[v].exp_x);
      check($sformatf("vec%0d_moving", v), 32'(moving), vecs[v].exp_mov);
    end

    // Clamp at the right edge, then run left into 0 and stay there.
    rst = 0; bl = 0; br = 1; en = 1;
    run(900);
    check("clamp_right", 32'(x_paddle1), XMAX);
    bl = 1; br = 0;
    run(1800);
    check("clamp_left", 32'(x_paddle1), 0);
    run(50);
    check("clamp_left_nowrap", 32'(x_paddle1), 0);

    // Conflict: both held freezes; releasing right restarts at slow step.
    bl = 0; br = 1;
    run(200);
    bl = 1;
    run(40);
    check("conflict_moving", 32'(moving), 0);
    xr = m_x;
    run(30);
    check("conflict_frozen", 32'(x_paddle1), 32'(xr));
    br = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      clk_cycle();
      if (m_dir == -1 && m_hold == 1) found = 1;
    end
    check("conflict_first_tick_found", 32'(found), 1);
    check("conflict_slow_step", 32'(x_paddle1), 32'(xr - SLOW));

    // Enable low during a right move freezes the paddle.
    bl = 0; br = 1;
    run(60);
    check("enable_moving_before", 32'(moving), 1);
    en = 0;
    run(1);
    check("enable_low_moving", 32'(moving), 0);
    xr = m_x;
    run(30);
    check("enable_low_frozen", 32'(x_paddle1), 32'(xr));

    // Reset landing on a tick edge applies no step.
    en = 1;
    run(30);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_cyc == TICK - 1) found = 1;
      else clk_cycle();
    end
    check("rst_tick_align_found", 32'(found), 1);
    check("rst_tick_pre_moving", 32'(moving), 1);
    rst = 1;
    run(1);
    rst = 0;
    check("rst_tick_x", 32'(x_paddle1), XRST);
    check("rst_tick_moving", 32'(moving), 0);

    // Random segments against the model.
    for (int s = 0; s < 60; s++) begin
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 19) == 0);
      clk_cycle();
      rst = 0;
      run($urandom_range(1, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
